// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
//
// Each transaction runs IDLE -> ACCESS (-> RETURN for reads) -> IDLE. The winner's
// command is latched in IDLE, so requesters may change their inputs once acked.
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   rN_req/we/addr/wdata   requester N command, req held until rN_ack
//   rN_ack                 one-cycle pulse when requester N's access hits the RAM
//   rN_rdata/rN_rvalid     requester N read data and its one-cycle valid pulse
//   m_addr/m_data/m_rw     RAM address, write data, write enable
//   m_q                    RAM read data, valid one cycle after the address
//   busy, grant_id         not-idle flag, owner of the current/last transaction
module mem_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rvalid,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rvalid,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_data,
    output logic          m_rw,
    input  logic [DW-1:0] m_q,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {StIdle, StAccess, StReturn} state_e;

    state_e        state_q, state_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          grant_q;
    logic          last_grant_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic [1:0]    rvalid_q;

    logic          any_req;
    logic          winner;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        any_req = r0_req | r1_req;
        if (r0_req && r1_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = r1_req;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = we_q ? StIdle : StReturn;
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Command latch, read-data capture and rvalid pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid_q     <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            if (state_q == StIdle && any_req) begin
                we_q         <= winner ? r1_we    : r0_we;
                addr_q       <= winner ? r1_addr  : r0_addr;
                data_q       <= winner ? r1_wdata : r0_wdata;
                grant_q      <= winner;
                last_grant_q <= winner;
            end
            // m_q reflects the address presented during ACCESS.
            if (state_q == StReturn) begin
                if (grant_q) begin
                    rdata1_q    <= m_q;
                    rvalid_q[1] <= 1'b1;
                end else begin
                    rdata0_q    <= m_q;
                    rvalid_q[0] <= 1'b1;
                end
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        m_addr    = addr_q;
        m_data    = data_q;
        m_rw      = (state_q == StAccess) && we_q;
        r0_ack    = (state_q == StAccess) && !grant_q;
        r1_ack    = (state_q == StAccess) && grant_q;
        r0_rdata  = rdata0_q;
        r1_rdata  = rdata1_q;
        r0_rvalid = rvalid_q[0];
        r1_rvalid = rvalid_q[1];
        busy      = (state_q != StIdle);
        grant_id  = grant_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM and a
// scoreboard of expected acks and read returns checked by a negedge monitor.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_ack, r0_rvalid, r1_ack, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_rw;
    logic [DW-1:0] m_q;
    logic          busy, grant_id;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r0_rvalid (r0_rvalid),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .r1_rvalid (r1_rvalid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_rw      (m_rw),
        .m_q       (m_q),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: read data valid one cycle after the address
    logic [DW-1:0] mem [0:4095];
    always @(posedge clock) begin
        if (m_rw) mem[m_addr] <= m_data;
        m_q <= mem[m_addr];
    end

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    logic ack_q[$];
    rd_t  rd_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Every ack / rvalid must match the next scoreboard entry.
    always @(negedge clock) begin
        rd_t e;
        if (!reset) begin
            if (r0_ack || r1_ack) begin
                check("ack_onehot", {r0_ack, r1_ack} != 2'b11, 1);
                check("ack_expected", ack_q.size() != 0, 1);
                if (ack_q.size() != 0) check("ack_id", r1_ack, ack_q.pop_front());
            end
            if (r0_rvalid || r1_rvalid) begin
                check("rvalid_onehot", {r0_rvalid, r1_rvalid} != 2'b11, 1);
                check("rvalid_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check("rvalid_id", r1_rvalid, e.id);
                    check("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
                end
            end
        end
    end

    initial begin
        mem[12'h020] <= 16'h5A5A;
        mem[12'h030] <= 16'h1111;
        mem[12'hFFF] <= 16'h1234;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_m_rw", m_rw, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_data", m_data, 0);
        check("rst_acks", {r0_ack, r1_ack, r0_rvalid, r1_rvalid}, 0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        reset = 1'b0;

        // r0 write 0x010 <= 0xBEEF
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h010; r0_wdata = 16'hBEEF;
        ack_q.push_back(1'b0);
        tick;
        check("wr_ack", r0_ack, 1);
        check("wr_m_rw", m_rw, 1);
        check("wr_m_addr", m_addr, 12'h010);
        check("wr_m_data", m_data, 16'hBEEF);
        check("wr_busy1", busy, 1);
        check("wr_grant", grant_id, 0);
        r0_req = 1'b0; r0_we = 1'b0;
        tick;
        check("wr_busy2", busy, 0);
        check("wr_m_rw2", m_rw, 0);
        check("wr_mem", mem[12'h010], 16'hBEEF);

        // r1 read 0x010
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h010;
        ack_q.push_back(1'b1);
        rd_q.push_back('{id: 1'b1, data: 16'hBEEF});
        tick;
        check("rd_ack", r1_ack, 1);
        check("rd_m_rw", m_rw, 0);
        check("rd_m_addr", m_addr, 12'h010);
        check("rd_grant", grant_id, 1);
        r1_req = 1'b0;
        tick;
        check("rd_busy_ret", busy, 1);
        check("rd_no_early_rvalid", r1_rvalid, 0);
        tick;
        check("rd_rvalid", r1_rvalid, 1);
        check("rd_rdata", r1_rdata, 16'hBEEF);
        check("rd_r0_untouched", {r0_rvalid, r0_rdata}, 0);
        tick;
        check("rd_rvalid_pulse", r1_rvalid, 0);
        check("rd_rdata_hold", r1_rdata, 16'hBEEF);

        // r0 read 0x020, address changed during ACCESS must be ignored
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h020;
        ack_q.push_back(1'b0);
        rd_q.push_back('{id: 1'b0, data: 16'h5A5A});
        tick;
        check("chg_ack", r0_ack, 1);
        r0_addr = 12'h030; r0_req = 1'b0;
        tick;
        check("chg_m_addr", m_addr, 12'h020);
        tick;
        check("chg_rvalid", r0_rvalid, 1);
        check("chg_rdata", r0_rdata, 16'h5A5A);
        check("chg_r1_hold", r1_rdata, 16'hBEEF);

        // Reset during RETURN drops the pending rvalid
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h030;
        ack_q.push_back(1'b1);
        tick;
        r1_req = 1'b0;
        tick;
        check("ret_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("ret_rst_busy", busy, 0);
        check("ret_rst_rdata", {r0_rdata, r1_rdata}, 0);
        tick;
        reset = 1'b0;
        tick;
        tick;
        check("ret_no_rvalid", {r0_rvalid, r1_rvalid}, 0);

        // Fresh reset, then both requesters hold req: grants alternate r0, r1, ...
        reset = 1'b1;
        tick;
        reset = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h100; r0_wdata = 16'hA000;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'h101; r1_wdata = 16'hB000;
        for (int i = 0; i < 4; i++) ack_q.push_back(i[0]);
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i % 2 == 0) begin
                check("rr_grant", grant_id, (i / 2) % 2);
                check("rr_m_rw", m_rw, 1);
                check("rr_m_addr", m_addr, 12'h100 + (i / 2) % 2);
            end else begin
                check("rr_idle", busy, 0);
            end
        end
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        tick;
        check("rr_mem0", mem[12'h100], 16'hA000);
        check("rr_mem1", mem[12'h101], 16'hB000);

        // Reset during a write ACCESS to 0xFFF aborts it
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'hFFF; r0_wdata = 16'hDEAD;
        tick;
        check("abort_pre_m_rw", m_rw, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_m_rw", m_rw, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", r0_ack, 0);
        r0_req = 1'b0; r0_we = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        repeat (3) tick;
        check("abort_mem", mem[12'hFFF], 16'h1234);
        check("abort_busy_after", busy, 0);

        // Idle for 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick;
            check("idle_quiet", {m_rw, r0_ack, r1_ack, r0_rvalid, r1_rvalid, busy}, 0);
        end

        check("sb_ack_drained", ack_q.size(), 0);
        check("sb_rd_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 12, RAM address width.
REQ-002 Parameter DW, default 16, RAM data width.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 r0_req  in  1  requester 0 access request, held until r0_ack.
REQ-006 r0_we  in  1  requester 0 write (1) / read (0).
REQ-007 r0_addr  in  AW  requester 0 address.
REQ-008 r0_wdata  in  DW  requester 0 write data.
REQ-009 r0_ack  out  1  one-cycle pulse: requester 0 access issued to RAM.
REQ-010 r0_rdata  out  DW  requester 0 read data, valid when r0_rvalid.
REQ-011 r0_rvalid  out  1  one-cycle pulse: r0_rdata valid.
REQ-012 r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_rvalid: same directions, widths and meanings as r0_* for requester 1.
REQ-013 m_addr  out  AW  RAM address.
REQ-014 m_data  out  DW  RAM write data.
REQ-015 m_rw  out  1  RAM write enable, 1 = write.
REQ-016 m_q  in  DW  RAM read data, valid one cycle after address presented.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 grant_id  out  1  id of requester owning the current/last transaction.

Function
REQ-019 FSM states IDLE, ACCESS, RETURN; all outputs registered or decoded from registered state.
REQ-020 IDLE: no req sampled -> stay IDLE; any req sampled -> latch winner's we/addr/wdata, set grant_id, go ACCESS.
REQ-021 Arbitration: one requester -> it wins; both -> the one not equal to last_grant wins (round-robin); last_grant updated on each grant.
REQ-022 ACCESS lasts exactly one cycle: m_addr/m_data = latched values, m_rw = latched we, winner's ack = 1.
REQ-023 ACCESS with write -> IDLE; ACCESS with read -> RETURN.
REQ-024 RETURN lasts one cycle: winner's rdata <= m_q at end of RETURN; winner's rvalid = 1 in the following cycle only; -> IDLE.
REQ-025 Latency (req sampled at edge 0): ack and m_rw/m_addr in cycle 1; read rvalid/rdata in cycle 3; write done, IDLE in cycle 2.
REQ-026 m_rw = 0 in every state except ACCESS-with-write; m_addr/m_data hold last latched values otherwise.
REQ-027 req is sampled only in IDLE; changes on req/we/addr/wdata during ACCESS or RETURN are ignored.
REQ-028 A requester still asserting req in the IDLE cycle after its ack is treated as a new request.
REQ-029 rdata of each requester holds its last read value until its next read completes; the non-winner's rdata/rvalid never change.
REQ-030 At most one ack and one rvalid asserted per cycle; ack and rvalid never target the non-granted requester.
REQ-031 Address and data are passed unmodified, no wrap or arithmetic; all AW/DW values legal.

Reset
REQ-032 reset asserted -> immediately: state IDLE, m_rw 0, m_addr 0, m_data 0, all ack/rvalid 0, all rdata 0, busy 0, grant_id 0, last_grant 1 (requester 0 wins first tie).
REQ-033 reset mid-ACCESS aborts the access (m_rw drops asynchronously); mid-RETURN drops the pending rvalid; no replay after release.

Verification
REQ-034 r0 write addr 0x010 data 0xBEEF alone -> r0_ack and m_rw=1, m_addr=0x010, m_data=0xBEEF in cycle 1; busy 0 in cycle 2.
REQ-035 r1 read addr 0x010 after above, RAM model returns 0xBEEF -> r1_ack cycle 1, r1_rvalid=1 with r1_rdata=0xBEEF in cycle 3, r0_rdata unchanged.
REQ-036 After reset, r0 and r1 both hold req continuously -> grants alternate r0, r1, r0, r1; grant_id toggles each transaction.
REQ-037 Read in flight, r0 changes addr during ACCESS -> m_addr keeps originally latched address; rdata from that address.
REQ-038 reset pulsed during ACCESS of a write to 0xFFF -> m_rw 0 at once, RAM location 0xFFF unchanged, no ack or rvalid after release, busy 0.
REQ-039 Idle bench, no req for 100 cycles -> m_rw, all ack and rvalid stay 0; busy stays 0.
